estagio_writeback: RTL and testbench
====================================

Name: estagio_writeback

Overview:
Parametrised successor to the single-cycle memToReg writeback mux. Registered MEM/WB pipeline stage:
- selects the writeback value from four sources;
- sign/zero-extends sub-word loads;
- holds or flushes under hazard control;
- exposes the registered result for forwarding;
- counts retired register writes.

It sits between the data memory stage and the register file write port.

Parameters:
LARGURA, 32, datapath width in bits; must be a multiple of 8 and at least 32.
BITS_REG, 5, register index width; register 0 is hardwired zero.
LARG_CONT, 32, width of the retired-write counter.

Ports:
clk  in  1  single clock; all state updates on rising edge
reset  in  1  synchronous, active-high
valido_in  in  1  MEM stage presents a valid instruction
stall  in  1  hold WB register contents
flush  in  1  load a bubble into WB register
lerDado  in  LARGURA  raw word read from data memory
resultadoUla  in  LARGURA  ALU result; low 2 bits also give the load byte address
pcMais4  in  LARGURA  return address for jal/jalr
imediato  in  LARGURA  pre-shifted immediate for lui
memToReg  in  2  source select: 00 ULA, 01 memory, 10 pcMais4, 11 imediato
tamanho  in  2  load size: 00 word, 01 half, 10 byte, 11 treated as word
sinalExt  in  1  1 = sign-extend sub-word load, 0 = zero-extend
regDestino_in  in  BITS_REG  destination register index
escreveReg_in  in  1  instruction writes the register file
escreveDado  out  LARGURA  registered writeback value
regDestino  out  BITS_REG  registered destination index
escreveReg  out  1  registered write enable to register file
valido  out  1  WB register holds a valid instruction
contRetirados  out  LARG_CONT  number of committed register writes

Behaviour:
- Reset: all outputs are 0. Sync reset has priority over every other input.
- Update priority each cycle: reset > flush > stall > load.
- Load: capture the next-state values into the WB register. Latency is exactly 1 cycle from inputs to outputs.
- Flush: `valido`=0 and `escreveReg`=0. `escreveDado` and `regDestino` are cleared to 0.
- Stall (no flush): all WB register outputs hold their previous value. `contRetirados` does not increment.
- Next-state `valido` = `valido_in`.
- Next-state `escreveReg` = `valido_in` AND `escreveReg_in` AND (`regDestino_in` != 0).
- Next-state `regDestino` = `regDestino_in`.
- Memory value path, with `end` = `resultadoUla[1:0]` (little-endian):
  - byte: lane `end` (bits 8*end+7 : 8*end), extended to LARGURA;
  - half: `end[1]` selects the upper or lower 16 bits; `end[0]` is ignored and misalignment is not trapped; extended to LARGURA;
  - word / size 11: `lerDado` unchanged;
  - extension: replicate the sign bit if `sinalExt`=1, else zero-fill.
- Next-state `escreveDado` = mux on `memToReg` of (`resultadoUla`, extended memory value, `pcMais4`, `imediato`).
- Suppression: if `valido_in`=0, the data is still captured but `escreveReg`=0. When writing to r0, `escreveDado` is captured but `escreveReg`=0.
- Counter: `contRetirados` increments by 1 on each cycle where a load occurs with next-state `escreveReg`=1. It wraps modulo 2^LARG_CONT to 0 with no flag.
- Flush/stall/reset do not increment the counter. A simultaneous stall and flush is treated as flush. A reset in the middle of a stall clears everything.
- Forwarding: consumers use the registered `escreveDado`/`regDestino`/`escreveReg` directly. There is no combinational input-to-output path.

Test Plan:
- Reset: hold `reset`=1 with all inputs nonzero for 2 cycles -> all outputs 0, `contRetirados`=0; release reset -> first load appears 1 cycle later.
- Source select: `resultadoUla`=0x00000010, `pcMais4`=0x00400008, `imediato`=0x12340000, `memToReg`=00/10/11 on successive cycles, `regDestino_in`=8 -> `escreveDado` 0x00000010, 0x00400008, 0x12340000 on cycles 1/2/3; `escreveReg`=1; counter reaches 3.
- Load extension: `lerDado`=0x80FF7F01, `memToReg`=01:
  - byte, `end`=2, `sinalExt`=1 -> 0xFFFFFFFF;
  - byte, `end`=1, `sinalExt`=0 -> 0x0000007F;
  - half, `end`=2, `sinalExt`=1 -> 0xFFFF80FF;
  - word -> 0x80FF7F01.
- Hazard control: load value 0xA5 to r3, then assert `stall` 3 cycles with changing inputs -> outputs stay 0xA5/3/1 and the counter is unchanged. Then assert `stall`+`flush` together -> `valido`=0, `escreveReg`=0, outputs 0.
- Zero register and invalid: `regDestino_in`=0 with `escreveReg_in`=1 -> `escreveReg`=0 and no count. `valido_in`=0 -> `valido`=0, `escreveReg`=0.
- Counter wrap: LARG_CONT=4, 17 valid writes -> `contRetirados` goes 15 -> 0 -> 1.

Source files
------------

// File: rtl/estagio_writeback_if.sv
// MEM -> WB bus: writeback sources, load controls, hazard controls and the
// registered WB outputs consumed by the register file and forwarding logic.
interface estagio_writeback_if #(
  parameter int unsigned LARGURA   = 32,
  parameter int unsigned BITS_REG  = 5,
  parameter int unsigned LARG_CONT = 32
);
  logic                 valido_in;
  logic                 stall;
  logic                 flush;
  logic [LARGURA-1:0]   lerDado;
  logic [LARGURA-1:0]   resultadoUla;
  logic [LARGURA-1:0]   pcMais4;
  logic [LARGURA-1:0]   imediato;
  logic [1:0]           memToReg;
  logic [1:0]           tamanho;
  logic                 sinalExt;
  logic [BITS_REG-1:0]  regDestino_in;
  logic                 escreveReg_in;

  logic [LARGURA-1:0]   escreveDado;
  logic [BITS_REG-1:0]  regDestino;
  logic                 escreveReg;
  logic                 valido;
  logic [LARG_CONT-1:0] contRetirados;

  modport master (
    output valido_in, stall, flush, lerDado, resultadoUla, pcMais4, imediato,
           memToReg, tamanho, sinalExt, regDestino_in, escreveReg_in,
    input  escreveDado, regDestino, escreveReg, valido, contRetirados
  );

  modport slave (
    input  valido_in, stall, flush, lerDado, resultadoUla, pcMais4, imediato,
           memToReg, tamanho, sinalExt, regDestino_in, escreveReg_in,
    output escreveDado, regDestino, escreveReg, valido, contRetirados
  );
endinterface

// File: rtl/estagio_writeback.sv
// Registered MEM/WB stage: writeback source mux, sub-word load extension,
// stall/flush control and a retired register-write counter.
module estagio_writeback #(
  parameter int unsigned LARGURA   = 32,
  parameter int unsigned BITS_REG  = 5,
  parameter int unsigned LARG_CONT = 32
) (
  input  logic               clk,
  input  logic               reset,
  estagio_writeback_if.slave bus
);

  logic [1:0]           ender;
  logic [7:0]           byte_sel;
  logic [15:0]          half_sel;
  logic [LARGURA-1:0]   mem_ext;
  logic [LARGURA-1:0]   dado_sel;
  logic                 escreve_ok;

  logic [LARGURA-1:0]   escreve_dado_q, escreve_dado_d;
  logic [BITS_REG-1:0]  reg_destino_q,  reg_destino_d;
  logic                 escreve_reg_q,  escreve_reg_d;
  logic                 valido_q,       valido_d;
  logic [LARG_CONT-1:0] cont_q,         cont_d;

  assign ender = bus.resultadoUla[1:0];

  // Little-endian lane pick, then sign or zero extension to the datapath width
  always_comb begin : extensao
    byte_sel = bus.lerDado[7:0];
    case (ender)
      2'd1:    byte_sel = bus.lerDado[15:8];
      2'd2:    byte_sel = bus.lerDado[23:16];
      2'd3:    byte_sel = bus.lerDado[31:24];
      default: byte_sel = bus.lerDado[7:0];
    endcase
    half_sel = ender[1] ? bus.lerDado[31:16] : bus.lerDado[15:0];
    mem_ext  = bus.lerDado;
    case (bus.tamanho)
      2'b01:   mem_ext = {{(LARGURA-16){bus.sinalExt & half_sel[15]}}, half_sel};
      2'b10:   mem_ext = {{(LARGURA-8){bus.sinalExt & byte_sel[7]}}, byte_sel};
      default: mem_ext = bus.lerDado;
    endcase
  end

  always_comb begin : fonte
    dado_sel = bus.resultadoUla;
    case (bus.memToReg)
      2'b01:   dado_sel = mem_ext;
      2'b10:   dado_sel = bus.pcMais4;
      2'b11:   dado_sel = bus.imediato;
      default: dado_sel = bus.resultadoUla;
    endcase
  end

  // Register 0 is hardwired zero, so writes to it never reach the register file
  assign escreve_ok = bus.valido_in & bus.escreveReg_in & (bus.regDestino_in != '0);

  // Flush beats stall; a stall holds every field including the counter
  always_comb begin : proximo
    escreve_dado_d = escreve_dado_q;
    reg_destino_d  = reg_destino_q;
    escreve_reg_d  = escreve_reg_q;
    valido_d       = valido_q;
    cont_d         = cont_q;
    if (bus.flush) begin
      escreve_dado_d = '0;
      reg_destino_d  = '0;
      escreve_reg_d  = 1'b0;
      valido_d       = 1'b0;
    end else if (!bus.stall) begin
      escreve_dado_d = dado_sel;
      reg_destino_d  = bus.regDestino_in;
      escreve_reg_d  = escreve_ok;
      valido_d       = bus.valido_in;
      if (escreve_ok) begin
        cont_d = cont_q + LARG_CONT'(1);
      end
    end
  end

  always_ff @(posedge clk) begin : registro
    if (reset) begin
      escreve_dado_q <= '0;
      reg_destino_q  <= '0;
      escreve_reg_q  <= 1'b0;
      valido_q       <= 1'b0;
      cont_q         <= '0;
    end else begin
      escreve_dado_q <= escreve_dado_d;
      reg_destino_q  <= reg_destino_d;
      escreve_reg_q  <= escreve_reg_d;
      valido_q       <= valido_d;
      cont_q         <= cont_d;
    end
  end

  assign bus.escreveDado   = escreve_dado_q;
  assign bus.regDestino    = reg_destino_q;
  assign bus.escreveReg    = escreve_reg_q;
  assign bus.valido        = valido_q;
  assign bus.contRetirados = cont_q;

endmodule

// File: tb/tb_estagio_writeback.sv
// Bench for estagio_writeback: directed test-plan cases plus randomized traffic
// against a behavioural model; a second instance uses a 4-bit counter for wrap.
module tb_estagio_writeback;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  estagio_writeback_if #(.LARGURA(32), .BITS_REG(5), .LARG_CONT(32)) bus ();
  estagio_writeback_if #(.LARGURA(32), .BITS_REG(5), .LARG_CONT(4))  bus4 ();

  assign bus4.valido_in     = bus.valido_in;
  assign bus4.stall         = bus.stall;
  assign bus4.flush         = bus.flush;
  assign bus4.lerDado       = bus.lerDado;
  assign bus4.resultadoUla  = bus.resultadoUla;
  assign bus4.pcMais4       = bus.pcMais4;
  assign bus4.imediato      = bus.imediato;
  assign bus4.memToReg      = bus.memToReg;
  assign bus4.tamanho       = bus.tamanho;
  assign bus4.sinalExt      = bus.sinalExt;
  assign bus4.regDestino_in = bus.regDestino_in;
  assign bus4.escreveReg_in = bus.escreveReg_in;

  estagio_writeback #(.LARGURA(32), .BITS_REG(5), .LARG_CONT(32)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  estagio_writeback #(.LARGURA(32), .BITS_REG(5), .LARG_CONT(4)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4));

  // Reference state
  logic [31:0] m_dado;
  logic [4:0]  m_reg;
  logic        m_escr;
  logic        m_valido;
  logic [31:0] m_cont;
  int          m_cont4;

  task automatic verifica(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] valor_memoria();
    int unsigned ender = bus.resultadoUla % 4;
    int unsigned v;
    case (bus.tamanho)
      2'b10: begin
        v = (bus.lerDado >> (8 * ender)) % 256;
        if (bus.sinalExt && v >= 128) v = v + 32'hFFFF_FF00;
      end
      2'b01: begin
        v = (bus.lerDado >> (16 * (ender / 2))) % 65536;
        if (bus.sinalExt && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: v = bus.lerDado;
    endcase
    return v;
  endfunction

  task automatic modelo();
    if (reset) begin
      m_dado = 0; m_reg = 0; m_escr = 0; m_valido = 0; m_cont = 0; m_cont4 = 0;
    end else if (bus.flush) begin
      m_dado = 0; m_reg = 0; m_escr = 0; m_valido = 0;
    end else if (!bus.stall) begin
      case (bus.memToReg)
        2'b00: m_dado = bus.resultadoUla;
        2'b01: m_dado = valor_memoria();
        2'b10: m_dado = bus.pcMais4;
        default: m_dado = bus.imediato;
      endcase
      m_reg    = bus.regDestino_in;
      m_valido = bus.valido_in;
      m_escr   = bus.valido_in && bus.escreveReg_in && (bus.regDestino_in != 0);
      if (m_escr) begin
        m_cont  = m_cont + 1;
        m_cont4 = (m_cont4 + 1) % 16;
      end
    end
  endtask

  task automatic ciclo(input string tag);
    @(posedge clk);
    modelo();
    #1;
    verifica({tag, ".dado"},   bus.escreveDado,    m_dado);
    verifica({tag, ".reg"},    bus.regDestino,     m_reg);
    verifica({tag, ".escr"},   bus.escreveReg,     m_escr);
    verifica({tag, ".valido"}, bus.valido,         m_valido);
    verifica({tag, ".cont"},   bus.contRetirados,  m_cont);
    verifica({tag, ".cont4"},  bus4.contRetirados, 64'(m_cont4));
  endtask

  task automatic entradas(input logic vi, input logic st, input logic fl,
                          input logic [31:0] ld, input logic [31:0] ula,
                          input logic [31:0] pc, input logic [31:0] im,
                          input logic [1:0] m2r, input logic [1:0] tam,
                          input logic sx, input logic [4:0] rd, input logic we);
    bus.valido_in = vi; bus.stall = st; bus.flush = fl;
    bus.lerDado = ld; bus.resultadoUla = ula; bus.pcMais4 = pc; bus.imediato = im;
    bus.memToReg = m2r; bus.tamanho = tam; bus.sinalExt = sx;
    bus.regDestino_in = rd; bus.escreveReg_in = we;
  endtask

  task automatic aleatorio(input logic st, input logic fl);
    entradas(1'($urandom_range(0, 1)), st, fl, $urandom, $urandom, $urandom, $urandom,
             2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    // Reset held with every input nonzero
    reset = 1'b1;
    entradas(1, 1, 1, 32'hFFFF_FFFF, 32'h1234_5677, 32'h55, 32'h66, 2'b01, 2'b10, 1, 5'd9, 1);
    ciclo("reset0");
    ciclo("reset1");
    verifica("reset.dado0", bus.escreveDado, 0);
    verifica("reset.cont0", bus.contRetirados, 0);

    // Source select; first load right after reset release
    reset = 1'b0;
    entradas(1, 0, 0, 32'h0, 32'h0000_0010, 32'h0040_0008, 32'h1234_0000, 2'b00, 2'b00, 0, 5'd8, 1);
    ciclo("src_ula");
    verifica("src_ula.const", bus.escreveDado, 32'h0000_0010);
    bus.memToReg = 2'b10;
    ciclo("src_pc");
    verifica("src_pc.const", bus.escreveDado, 32'h0040_0008);
    bus.memToReg = 2'b11;
    ciclo("src_imm");
    verifica("src_imm.const", bus.escreveDado, 32'h1234_0000);
    verifica("src_imm.escr", bus.escreveReg, 1);
    verifica("src.cont3", bus.contRetirados, 3);

    // Sub-word load extension
    entradas(1, 0, 0, 32'h80FF_7F01, 32'h2, 0, 0, 2'b01, 2'b10, 1, 5'd4, 1);
    ciclo("lb_s2");
    verifica("lb_s2.const", bus.escreveDado, 32'hFFFF_FFFF);
    bus.resultadoUla = 32'h1; bus.sinalExt = 0;
    ciclo("lbu_1");
    verifica("lbu_1.const", bus.escreveDado, 32'h0000_007F);
    bus.resultadoUla = 32'h2; bus.sinalExt = 1; bus.tamanho = 2'b01;
    ciclo("lh_s2");
    verifica("lh_s2.const", bus.escreveDado, 32'hFFFF_80FF);
    bus.tamanho = 2'b00;
    ciclo("lw");
    verifica("lw.const", bus.escreveDado, 32'h80FF_7F01);

    // Stall holds, stall+flush clears
    entradas(1, 0, 0, 0, 32'hA5, 0, 0, 2'b00, 2'b00, 0, 5'd3, 1);
    ciclo("haz_load");
    for (int i = 0; i < 3; i++) begin
      aleatorio(1, 0);
      ciclo("haz_stall");
      verifica("haz_stall.const", bus.escreveDado, 32'hA5);
      verifica("haz_stall.cont", bus.contRetirados, 8);
    end
    aleatorio(1, 1);
    ciclo("haz_flush");
    verifica("haz_flush.valido", bus.valido, 0);
    verifica("haz_flush.dado", bus.escreveDado, 0);

    // r0 and invalid suppression
    entradas(1, 0, 0, 0, 32'h77, 0, 0, 2'b00, 2'b00, 0, 5'd0, 1);
    ciclo("r0");
    verifica("r0.escr", bus.escreveReg, 0);
    verifica("r0.dado", bus.escreveDado, 32'h77);
    entradas(0, 0, 0, 0, 32'h88, 0, 0, 2'b00, 2'b00, 0, 5'd7, 1);
    ciclo("invalid");
    verifica("invalid.valido", bus.valido, 0);
    verifica("invalid.escr", bus.escreveReg, 0);

    // Counter wrap on the 4-bit instance
    reset = 1'b1;
    ciclo("wrap_rst");
    reset = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      entradas(1, 0, 0, $urandom, $urandom, $urandom, $urandom, 2'b00, 2'b00, 0,
               5'(1 + (i % 31)), 1);
      ciclo("wrap");
      if (i == 15) verifica("wrap.15", bus4.contRetirados, 15);
      if (i == 16) verifica("wrap.0",  bus4.contRetirados, 0);
      if (i == 17) verifica("wrap.1",  bus4.contRetirados, 1);
    end

    // Randomized traffic with occasional hazards and resets
    for (int i = 0; i < 400; i++) begin
      aleatorio(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 7) == 0));
      reset = 1'($urandom_range(0, 63) == 0);
      ciclo("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
